// File: rtl/float_to_int_if.sv
// Strobe/ack bus between the float-to-int converter and its producer/consumer.
// The producer/consumer side uses master; the converter uses slave.
interface float_to_int_if;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;
    logic        output_invalid;
    logic        output_inexact;

    modport master (
        output input_a,
        output input_a_stb,
        input  input_a_ack,
        input  output_z,
        input  output_z_stb,
        output output_z_ack,
        input  output_invalid,
        input  output_inexact
    );

    modport slave (
        input  input_a,
        input  input_a_stb,
        output input_a_ack,
        output output_z,
        output output_z_stb,
        input  output_z_ack,
        output output_invalid,
        output output_inexact
    );
endinterface

// File: rtl/float_to_int.sv
// Sequential IEEE-754 single to signed 32-bit integer converter with
// round-to-nearest-even or truncate, reporting invalid and inexact flags.
module float_to_int #(
    parameter int unsigned ROUND_MODE = 1
) (
    input logic           clock,
    input logic           reset_n,
    float_to_int_if.slave bus
);

    localparam logic [31:0] MinInt = 32'h8000_0000;
    localparam logic [31:0] MaxInt = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        StGetA,
        StUnpack,
        StSpecial,
        StAlign,
        StRound,
        StConvert,
        StPutZ
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        m_q, m_d;
    logic signed [9:0]  e_q, e_d;
    logic               s_q, s_d;
    logic               guard_q, guard_d;
    logic               sticky_q, sticky_d;
    logic [31:0]        z_q, z_d;
    logic               z_stb_q, z_stb_d;
    logic               a_ack_q, a_ack_d;
    logic               invalid_q, invalid_d;
    logic               inexact_q, inexact_d;

    logic               exp_all_ones;
    logic               frac_nonzero;

    assign exp_all_ones = (a_q[30:23] == 8'hFF);
    assign frac_nonzero = (a_q[22:0] != 23'd0);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        m_d       = m_q;
        e_d       = e_q;
        s_d       = s_q;
        guard_d   = guard_q;
        sticky_d  = sticky_q;
        z_d       = z_q;
        z_stb_d   = z_stb_q;
        a_ack_d   = a_ack_q;
        invalid_d = invalid_q;
        inexact_d = inexact_q;

        unique case (state_q)
            StGetA: begin
                a_ack_d = 1'b1;
                if (bus.input_a_stb && a_ack_q) begin
                    a_d     = bus.input_a;
                    a_ack_d = 1'b0;
                    state_d = StUnpack;
                end
            end

            StUnpack: begin
                m_d       = {(a_q[30:23] != 8'd0), a_q[22:0], 8'd0};
                e_d       = $signed({2'b00, a_q[30:23]}) - 10'sd127;
                s_d       = a_q[31];
                guard_d   = 1'b0;
                sticky_d  = 1'b0;
                invalid_d = 1'b0;
                inexact_d = 1'b0;
                state_d   = StSpecial;
            end

            StSpecial: begin
                // Every special case goes straight to the output stage.
                state_d = StPutZ;
                z_stb_d = 1'b1;
                if (exp_all_ones && frac_nonzero) begin
                    z_d       = MinInt;
                    invalid_d = 1'b1;
                end else if (exp_all_ones) begin
                    z_d       = s_q ? MinInt : MaxInt;
                    invalid_d = 1'b1;
                end else if (a_q == 32'hCF00_0000) begin
                    z_d = MinInt;
                end else if (e_q >= 10'sd31) begin
                    z_d       = s_q ? MinInt : MaxInt;
                    invalid_d = 1'b1;
                end else if (a_q[30:0] == 31'd0) begin
                    z_d = 32'd0;
                end else if (e_q < -10'sd1) begin
                    z_d       = 32'd0;
                    inexact_d = 1'b1;
                end else begin
                    z_stb_d = 1'b0;
                    state_d = StAlign;
                end
            end

            StAlign: begin
                if (e_q < 10'sd31) begin
                    m_d      = m_q >> 1;
                    guard_d  = m_q[0];
                    sticky_d = sticky_q | guard_q;
                    e_d      = e_q + 10'sd1;
                end else begin
                    state_d = StRound;
                end
            end

            StRound: begin
                inexact_d = guard_q | sticky_q;
                if (ROUND_MODE == 1 && guard_q && (sticky_q || m_q[0])) begin
                    m_d = m_q + 32'd1;
                end
                state_d = StConvert;
            end

            StConvert: begin
                z_d       = s_q ? (32'd0 - m_q) : m_q;
                invalid_d = 1'b0;
                z_stb_d   = 1'b1;
                state_d   = StPutZ;
            end

            StPutZ: begin
                a_ack_d = 1'b0;
                if (bus.output_z_ack && z_stb_q) begin
                    z_stb_d = 1'b0;
                    state_d = StGetA;
                end
            end

            default: begin
                state_d = StGetA;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StGetA;
            a_q       <= 32'd0;
            m_q       <= 32'd0;
            e_q       <= 10'sd0;
            s_q       <= 1'b0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            z_q       <= 32'd0;
            z_stb_q   <= 1'b0;
            a_ack_q   <= 1'b0;
            invalid_q <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            m_q       <= m_d;
            e_q       <= e_d;
            s_q       <= s_d;
            guard_q   <= guard_d;
            sticky_q  <= sticky_d;
            z_q       <= z_d;
            z_stb_q   <= z_stb_d;
            a_ack_q   <= a_ack_d;
            invalid_q <= invalid_d;
            inexact_q <= inexact_d;
        end
    end

    assign bus.input_a_ack    = a_ack_q;
    assign bus.output_z       = z_q;
    assign bus.output_z_stb   = z_stb_q;
    assign bus.output_invalid = invalid_q;
    assign bus.output_inexact = inexact_q;

endmodule
